// File: rtl/weight_pattern_gen.sv
// weight_pattern_gen: enumerates every W-bit word with exactly k ones, in
// ascending numeric order, one word per valid/ready handshake.
// The successor of each word is the Gosper "next combination" step, with the
// division replaced by a right shift of trailing-zero count.
module weight_pattern_gen #(
    parameter int W  = 8,
    parameter int KW = 4,
    parameter int SW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic          ready,
    output logic [W-1:0]  pattern,
    output logic          valid,
    output logic          last,
    output logic [SW-1:0] seq,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = $clog2(W);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t        state_reg;
    logic [W-1:0]  pattern_reg;
    logic [W-1:0]  top_mask_reg;
    logic [SW-1:0] seq_reg;
    logic          valid_reg;
    logic          last_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_reg;

    // First word of the sequence (k ones in the LSBs) and final word
    // (k ones in the MSBs), both derived from the requested weight.
    logic [W-1:0]  low_mask;
    logic [W-1:0]  top_mask;
    logic          k_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_mask
            assign low_mask[gi] = (int'(k) > gi);
            assign top_mask[gi] = ((gi + int'(k)) >= W);
        end
    endgenerate

    assign k_illegal = (int'(k) > W);

    // Gosper successor datapath; only consulted on non-final, non-zero words,
    // so the addition below never carries out of W bits.
    logic [W-1:0]  low_bit;
    logic [W-1:0]  ripple;
    logic [W-1:0]  pattern_next;
    logic [CW-1:0] ctz;

    // Trailing-zero count of the current word as a priority encoder
    // (the lowest set bit is written last, so it wins).
    always_comb begin
        ctz = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (pattern_reg[i]) begin
                ctz = CW'(i);
            end
        end
    end

    assign low_bit      = pattern_reg & (~pattern_reg + W'(1));
    assign ripple       = pattern_reg + low_bit;
    assign pattern_next = ripple | (((pattern_reg ^ ripple) >> 2) >> ctz);

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            pattern_reg  <= '0;
            top_mask_reg <= '0;
            seq_reg      <= '0;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (k_illegal) begin
                            err_reg <= 1'b1;
                        end else begin
                            pattern_reg  <= low_mask;
                            top_mask_reg <= top_mask;
                            seq_reg      <= '0;
                            valid_reg    <= 1'b1;
                            busy_reg     <= 1'b1;
                            last_reg     <= (low_mask == top_mask);
                            state_reg    <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    // Word, index and last flag hold until the consumer takes them.
                    if (ready) begin
                        if (last_reg) begin
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            pattern_reg <= pattern_next;
                            seq_reg     <= seq_reg + SW'(1);
                            last_reg    <= (pattern_next == top_mask_reg);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pattern = pattern_reg;
    assign valid   = valid_reg;
    assign last    = last_reg;
    assign seq     = seq_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Directed testbench for weight_pattern_gen (W=8). Expected words come from a
// brute-force reference: the next word is the smallest larger value whose
// popcount equals k.
module tb_weight_pattern_gen;

    localparam int W  = 8;
    localparam int KW = 4;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k = '0;
    logic          ready = 1'b0;
    logic [W-1:0]  pattern;
    logic          valid;
    logic          last;
    logic [SW-1:0] seq;
    logic          busy;
    logic          done;
    logic          err;

    int tests_run = 0;
    int tests_failed = 0;
    int obs[$];

    weight_pattern_gen #(.W(W), .KW(KW), .SW(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .k(k), .ready(ready),
        .pattern(pattern), .valid(valid), .last(last), .seq(seq),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int popcnt(input int x);
        int n = 0;
        for (int i = 0; i < W; i++) n += (x >> i) & 1;
        return n;
    endfunction

    function automatic int ref_next(input int x, input int kk);
        for (int y = x + 1; y < (1 << W); y++) begin
            if (popcnt(y) == kk) return y;
        end
        return -1;
    endfunction

    // Runs one enumeration for weight kk; optionally random ready and a
    // start pulse with another k injected at seq == inj_seq.
    task automatic run_seq(input int kk, input bit rnd, input int exp_count,
                           input int exp_final, input int inj_seq);
        int  exp_pat, idx, bad;
        int  cur;
        bit  rdy, injected, finished;
        obs.delete();
        k = KW'(kk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_pat = (1 << kk) - 1;
        idx = 0;
        finished = 1'b0;
        injected = 1'b0;
        for (int cycles = 0; cycles < 1000 && !finished; cycles++) begin
            check("valid", 32'(valid), 1);
            check("busy", 32'(busy), 1);
            check("pattern", 32'(pattern), exp_pat);
            check("seq", 32'(seq), idx);
            check("last", 32'(last), 32'(idx == exp_count - 1));
            check("popcount", popcnt(int'(pattern)), kk);
            cur = int'(pattern);
            if (inj_seq >= 0 && idx == inj_seq && !injected) begin
                start = 1'b1;
                k = KW'(5);
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            ready = rdy;
            @(posedge clk); #1;
            if (rdy) begin
                $display("[TB] k=%0d seq=%0d pattern=%02h", kk, idx, cur);
                obs.push_back(cur);
                if (idx == exp_count - 1) finished = 1'b1;
                else begin
                    exp_pat = ref_next(exp_pat, kk);
                    idx++;
                end
            end
        end
        start = 1'b0;
        ready = 1'b0;
        check("completed", 32'(finished), 1);
        check("count", obs.size(), exp_count);
        bad = 0;
        for (int i = 1; i < obs.size(); i++) if (obs[i] <= obs[i-1]) bad++;
        check("ascending", bad, 0);
        check("done", 32'(done), 1);
        check("valid_after", 32'(valid), 0);
        check("busy_after", 32'(busy), 0);
        check("last_after", 32'(last), 0);
        check("pattern_hold", 32'(pattern), exp_final);
        check("seq_hold", 32'(seq), exp_count - 1);
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 0);
    endtask

    initial begin
        int hand_k2[7] = '{8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11};
        int guard;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pattern", 32'(pattern), 0);
        check("rst_seq", 32'(seq), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // k=2 with ready held high, checked against a hand table
        run_seq(2, 1'b0, 28, 8'hC0, -1);
        for (int i = 0; i < 7; i++) check("k2_hand", obs[i], hand_k2[i]);

        // Edge weights
        run_seq(0, 1'b0, 1, 8'h00, -1);
        run_seq(8, 1'b0, 1, 8'hFF, -1);
        run_seq(4, 1'b0, 70, 8'hF0, -1);

        // Backpressure with random ready
        run_seq(3, 1'b1, 56, 8'hE0, -1);

        // Start during EMIT is ignored
        run_seq(3, 1'b0, 56, 8'hE0, 3);

        // Illegal weight
        k = KW'(9);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", 32'(err), 1);
        check("err_valid", 32'(valid), 0);
        check("err_busy", 32'(busy), 0);
        check("err_done", 32'(done), 0);
        @(posedge clk); #1;
        check("err_clear", 32'(err), 0);
        check("err_valid2", 32'(valid), 0);
        $display("[TB] illegal k=9 start");

        // Asynchronous reset mid-EMIT at seq=5
        k = KW'(3);
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (int'(seq) != 5 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reach_seq5", 32'(seq), 5);
        ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("arst_pattern", 32'(pattern), 0);
        check("arst_valid", 32'(valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_seq", 32'(seq), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("post_rst_valid", 32'(valid), 0);
        end
        $display("[TB] reset mid-EMIT");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/weight_pattern_gen.md
Name: weight_pattern_gen

Overview:
- Inverse companion to the popcount block: given a target weight k, emits every W-bit word containing exactly k ones.
- Patterns come out in ascending numeric order, one per valid/ready handshake.
- Used as a stimulus source for popcount datapaths and for balanced-code enumeration.
- Sits between a control register (start, k) and a downstream consumer with ready backpressure.

Parameters:
W, 8, pattern width in bits (supported 4..16)
KW, 4, width of k input; must hold W (ceil log2(W+1))
SW, 7, width of seq output; must hold C(W, W/2)-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  begin enumeration for weight k; sampled only in IDLE
k  input  KW  target number of ones, legal 0..W
ready  input  1  consumer accepts current pattern when valid&&ready
pattern  output  W  current W-bit word with popcount k
valid  output  1  pattern is presented
last  output  1  current pattern is final of the sequence (only with valid)
seq  output  SW  0-based index of current pattern
busy  output  1  enumeration in progress
done  output  1  one-cycle pulse after final handshake
err  output  1  one-cycle pulse when start seen with k>W

Behaviour:
- Reset: reset=0 forces all outputs to 0 immediately and state to IDLE, including mid-EMIT; no partial sequence resumes after release.
- All outputs registered.
- States: IDLE, EMIT.
- IDLE
  - valid=0, busy=0.
  - start=1, k<=W: next cycle pattern=(1<<k)-1 (k=0 -> 0, k=W -> all ones), seq=0, valid=1, busy=1, state EMIT.
  - start=1, k>W: err=1 for exactly the next cycle; state stays IDLE, valid stays 0.
- EMIT
  - valid=1; pattern, seq and last hold stable while ready=0.
  - start is ignored in EMIT.
  - Handshake on a non-final pattern: next cycle pattern=next(pattern), seq=seq+1.
  - next(x): Gosper successor, computed within W bits.
    - c = lowest set bit of x.
    - r = x+c.
    - next = r | (((x^r)>>2) >> ctz(x)).
    - Division replaced by a priority-encoded shift; no divider.
  - last=1 exactly when pattern equals the k ones packed into the MSBs (k=0: pattern 0 is both first and last).
  - Handshake with last=1: next cycle valid=0, last=0, busy=0, done=1 for one cycle, state IDLE.
    - pattern and seq keep their final values until the next start.
  - The successor is never computed on the final pattern, so r never overflows.
- Sequence length is C(W,k); with W=8 the maximum is 70 (k=4).
- A start in the cycle done is high is accepted; IDLE is already entered.
- Throughput: one pattern per cycle with ready held 1.

Test Plan:
- Reset with W=8: assert reset=0 mid-EMIT at seq=5 -> pattern=0, valid=0, busy=0, seq=0 in the same cycle. After release, no valid until a new start.
- k=2, ready=1 constant:
  - Patterns in order 8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11, ... 8'hC0: 28 total.
  - seq runs 0..27; last=1 only with 8'hC0.
  - done pulses one cycle after the 8'hC0 handshake.
- Edge weights:
  - k=0 -> single pattern 8'h00 with last=1, then done.
  - k=8 -> single 8'hFF with last=1, then done.
  - k=4 -> 70 patterns ending at 8'hF0.
- Backpressure: k=3, ready driven by random toggling.
  - pattern/seq stable throughout every stall.
  - All 56 patterns distinct and strictly ascending.
  - Each pattern has popcount 3, checked by a popcount model.
- Illegal weight: start with k=9 -> err=1 for one cycle; valid, busy and done stay 0.
- Start during EMIT: start pulse with a different k at seq=3 -> ignored; sequence continues unchanged to completion.
